// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - pattern-ROM driven note sequencer producing phase increments and gate
module note_sequencer #(
    parameter int CLK_HZ = 25_000_000,
    parameter int AW     = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_restart,
    input  logic          i_tick_stb,
    input  logic          i_beat_stb,
    output logic [AW-1:0] o_rom_addr,
    input  logic [15:0]   i_rom_data,
    output logic [31:0]   o_phase_delta,
    output logic          o_phase_delta_valid,
    output logic          o_gate,
    output logic          o_note_stb
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, PLAY} state_t;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] ptr;
    logic [5:0]    len_cnt;
    logic [31:0]   tab [12];

    logic          word_loop;
    logic          word_rest;
    logic [3:0]    sem_idx;
    logic [31:0]   note_delta;
    logic          unused_octave_msb;

    // Octave-7 phase increment for semitone s (A = index 9 = 3520 Hz)
    function automatic logic [31:0] pitch_inc(input int s);
        real ratio;
        real x;
        case (s)
            0:       ratio = 0.5946035575013605;
            1:       ratio = 0.6299605249474366;
            2:       ratio = 0.6674199270850172;
            3:       ratio = 0.7071067811865476;
            4:       ratio = 0.7491535384383408;
            5:       ratio = 0.7937005259840998;
            6:       ratio = 0.8408964152537145;
            7:       ratio = 0.8908987181403393;
            8:       ratio = 0.9438743126816935;
            9:       ratio = 1.0;
            10:      ratio = 1.0594630943592953;
            default: ratio = 1.122462048309373;
        endcase
        x = 3520.0 * ratio * 4294967296.0 / real'(CLK_HZ);
        pitch_inc = 32'($rtoi(x + 0.5));
    endfunction

    for (genvar g = 0; g < 12; g++) begin : g_tab
        localparam logic [31:0] VAL = pitch_inc(g);
        assign tab[g] = VAL;
    end

    assign o_rom_addr        = ptr;
    assign unused_octave_msb = i_rom_data[7];

    always_comb begin
        next_state = state;
        // A loop word at address 0 would refetch itself forever, so it plays as a rest
        word_loop  = i_rom_data[15] && (ptr != '0);
        word_rest  = !word_loop && (i_rom_data[15] || i_rom_data[14] || (i_rom_data[3:0] > 4'd11));
        sem_idx    = (i_rom_data[3:0] > 4'd11) ? 4'd0 : i_rom_data[3:0];
        note_delta = tab[sem_idx] >> (3'd7 - i_rom_data[6:4]);

        case (state)
            IDLE:    if (i_enable && i_beat_stb) next_state = FETCH;
            FETCH:   next_state = DECODE;
            DECODE:  next_state = word_loop ? FETCH : PLAY;
            PLAY:    if (i_beat_stb) next_state = FETCH;
            default: next_state = IDLE;
        endcase

        if (!i_enable || i_restart) next_state = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr                 <= '0;
            len_cnt             <= '0;
            o_phase_delta       <= '0;
            o_phase_delta_valid <= 1'b0;
            o_gate              <= 1'b0;
            o_note_stb          <= 1'b0;
        end else begin
            o_phase_delta_valid <= 1'b0;
            o_note_stb          <= 1'b0;
            if (i_restart) begin
                ptr    <= '0;
                o_gate <= 1'b0;
            end else if (!i_enable) begin
                o_gate <= 1'b0;
            end else begin
                case (state)
                    DECODE: begin
                        if (word_loop) begin
                            ptr <= '0;
                        end else begin
                            o_note_stb <= 1'b1;
                            ptr        <= ptr + 1'b1;
                            len_cnt    <= i_rom_data[13:8];
                            if (word_rest) begin
                                o_gate <= 1'b0;
                            end else begin
                                o_gate              <= 1'b1;
                                o_phase_delta       <= note_delta;
                                o_phase_delta_valid <= 1'b1;
                            end
                        end
                    end
                    PLAY: begin
                        // A zero count means sustain: never decrements, gate stays up
                        if (i_tick_stb && (len_cnt != '0)) begin
                            len_cnt <= len_cnt - 1'b1;
                            if (len_cnt == 6'd1) o_gate <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
